irq_controller: RTL and testbench

- Upstream neighbour of the CPU control unit.
- Collects external interrupt lines, latches and masks them, and picks the highest-priority eligible line.
- Raises O_irq_active toward the control unit and, on the control unit's O_irq_ack pulse, returns a stable interrupt number for ISR entry.
- Blocks nesting until software signals end-of-interrupt (EOI); software configures it through a small 4-register bus slave.

---
 rtl/irq_controller.sv | 166 ++++++++++++++++
 tb/tb_irq_controller.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/irq_controller.sv
// Purpose : latch, mask and prioritise external interrupt lines; hand one line at a time to the control unit.
// Latency : raw edge to O_irq_active 4 cycles; ack to valid interrupt number 1 cycle.
// Backpress: no nesting - further interrupts wait in PENDING until EOI returns the block to IDLE.
module irq_controller #(
   parameter int          NUM_IRQ     = 8,
   parameter logic [15:0] SPURIOUS_ID = 16'h00FF
) (
   input  logic               I_clk,
   input  logic               I_reset_n,
   input  logic [NUM_IRQ-1:0] I_irq,
   input  logic               I_irq_ack,
   input  logic               I_eoi,
   output logic               O_irq_active,
   output logic [15:0]        O_irq_number,
   output logic               O_irq_number_valid,
   input  logic               I_reg_we,
   input  logic [1:0]         I_reg_addr,
   input  logic [15:0]        I_reg_wdata,
   output logic [15:0]        O_reg_rdata
);

   typedef enum logic {S_IDLE = 1'b0, S_SERVICE = 1'b1} state_t;

   state_t               r_state, w_state_nxt;
   logic [NUM_IRQ-1:0]   r_sync1, r_sync2, r_sync_d;
   logic [NUM_IRQ-1:0]   r_mask, r_mode, r_pend;
   logic [NUM_IRQ-1:0]   w_rise, w_pend_view, w_elig, w_win_oh, w_clr, w_wdata;
   logic [3:0]           w_win_idx, r_svc_idx, w_idx_nxt;
   logic                 w_take, w_spur, w_we_mask, w_we_mode, w_we_pend;
   logic                 r_active, r_num_vld, w_active_nxt, w_vld_nxt;
   logic [15:0]          r_num, w_num_nxt;
   logic                 w_unused;

   assign w_wdata   = I_reg_wdata[NUM_IRQ-1:0];
   assign w_unused  = ^I_reg_wdata;
   assign w_we_mask = I_reg_we & (I_reg_addr == 2'd0);
   assign w_we_mode = I_reg_we & (I_reg_addr == 2'd1);
   assign w_we_pend = I_reg_we & (I_reg_addr == 2'd2);

   // two-flop synchronizer plus one flop of history for rising-edge detection
   always_ff @(posedge I_clk or negedge I_reset_n) begin
      if (!I_reset_n) begin
         r_sync1  <= '0;
         r_sync2  <= '0;
         r_sync_d <= '0;
      end else begin
         r_sync1  <= I_irq;
         r_sync2  <= r_sync1;
         r_sync_d <= r_sync2;
      end
   end

   assign w_rise      = r_sync2 & ~r_sync_d;
   // level lines show the live synchronized level, edge lines the latched bit
   assign w_pend_view = (r_mode & r_pend) | (~r_mode & r_sync2);
   assign w_elig      = w_pend_view & r_mask;

   // lowest eligible index wins
   always_comb begin
      w_win_idx = '0;
      w_win_oh  = '0;
      for (int i = NUM_IRQ - 1; i >= 0; i--) begin
         if (w_elig[i]) begin
            w_win_idx   = 4'(i);
            w_win_oh    = '0;
            w_win_oh[i] = 1'b1;
         end
      end
   end

   // ack decisions use the pre-write, pre-edge eligible set
   assign w_take = I_irq_ack & (r_state == S_IDLE) & (|w_elig);
   assign w_spur = I_irq_ack & (r_state == S_IDLE) & ~(|w_elig);

   // clear sources: acked edge winner, W1C, and lines whose mode is being changed
   assign w_clr = (w_take    ? (w_win_oh & r_mode)  : '0)
                | (w_we_pend ? (w_wdata  & r_mode)  : '0)
                | (w_we_mode ? (w_wdata  ^ r_mode)  : '0);

   // config registers and edge-pending latch; a new edge wins over any clear
   always_ff @(posedge I_clk or negedge I_reset_n) begin
      if (!I_reset_n) begin
         r_mask <= '0;
         r_mode <= '0;
         r_pend <= '0;
      end else begin
         if (w_we_mask) r_mask <= w_wdata;
         if (w_we_mode) r_mode <= w_wdata;
         r_pend <= (r_pend & ~w_clr) | (w_rise & r_mode);
      end
   end

   // FSM state register
   always_ff @(posedge I_clk or negedge I_reset_n) begin
      if (!I_reset_n) r_state <= S_IDLE;
      else            r_state <= w_state_nxt;
   end

   // FSM next state: enter service on a real ack, leave on EOI
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:    if (w_take) w_state_nxt = S_SERVICE;
         S_SERVICE: if (I_eoi)  w_state_nxt = S_IDLE;
         default:   w_state_nxt = S_IDLE;
      endcase
   end

   // FSM outputs: next values of the registered control-unit signals
   always_comb begin
      w_active_nxt = 1'b0;
      w_vld_nxt    = r_num_vld;
      w_num_nxt    = r_num;
      w_idx_nxt    = r_svc_idx;
      case (r_state)
         S_IDLE: begin
            w_active_nxt = (|w_elig) & ~I_irq_ack;
            w_vld_nxt    = 1'b0;
            if (w_take) begin
               w_num_nxt = {12'd0, w_win_idx};
               w_vld_nxt = 1'b1;
               w_idx_nxt = w_win_idx;
            end else if (w_spur) begin
               w_num_nxt = SPURIOUS_ID;
               w_vld_nxt = 1'b1;
            end
         end
         S_SERVICE: begin
            if (I_eoi) w_vld_nxt = 1'b0;
         end
         default: ;
      endcase
   end

   // output registers
   always_ff @(posedge I_clk or negedge I_reset_n) begin
      if (!I_reset_n) begin
         r_active  <= 1'b0;
         r_num_vld <= 1'b0;
         r_num     <= '0;
         r_svc_idx <= '0;
      end else begin
         r_active  <= w_active_nxt;
         r_num_vld <= w_vld_nxt;
         r_num     <= w_num_nxt;
         r_svc_idx <= w_idx_nxt;
      end
   end

   assign O_irq_active       = r_active;
   assign O_irq_number       = r_num;
   assign O_irq_number_valid = r_num_vld;

   // combinational register read
   always_comb begin
      O_reg_rdata = '0;
      case (I_reg_addr)
         2'd0: O_reg_rdata = 16'(r_mask);
         2'd1: O_reg_rdata = 16'(r_mode);
         2'd2: O_reg_rdata = 16'(w_pend_view);
         2'd3: O_reg_rdata = {(r_state == S_SERVICE), 11'd0, r_svc_idx};
         default: O_reg_rdata = '0;
      endcase
   end

endmodule

// File: tb/tb_irq_controller.sv
// Purpose : directed and randomized check of irq_controller against a behavioural model.
// Latency : model is evaluated once per rising clock edge, outputs sampled 1 ns later.
// Backpress: n/a (bench drives all inputs directly).
module tb_irq_controller;

   logic        I_clk = 1'b0;
   logic        I_reset_n;
   logic [7:0]  I_irq;
   logic        I_irq_ack, I_eoi, I_reg_we;
   logic [1:0]  I_reg_addr;
   logic [15:0] I_reg_wdata;
   logic        O_irq_active, O_irq_number_valid;
   logic [15:0] O_irq_number, O_reg_rdata;

   int n_checks = 0;
   int n_err    = 0;

   // model state, in specification terms
   logic [7:0]  m_mask, m_mode, m_pend;
   logic [7:0]  h1, h2, h3;   // raw line samples taken 1, 2 and 3 edges ago
   logic        m_svc, m_vld, m_act;
   logic [15:0] m_num;
   logic [3:0]  m_idx;

   irq_controller dut (
      .I_clk(I_clk), .I_reset_n(I_reset_n), .I_irq(I_irq),
      .I_irq_ack(I_irq_ack), .I_eoi(I_eoi),
      .O_irq_active(O_irq_active), .O_irq_number(O_irq_number),
      .O_irq_number_valid(O_irq_number_valid),
      .I_reg_we(I_reg_we), .I_reg_addr(I_reg_addr), .I_reg_wdata(I_reg_wdata),
      .O_reg_rdata(O_reg_rdata)
   );

   always #5 I_clk = ~I_clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // what software sees in PENDING: edge lines latched, level lines the level seen 2 edges back
   function automatic logic [7:0] m_view();
      return (m_mode & m_pend) | (~m_mode & h2);
   endfunction

   function automatic logic [15:0] m_rdata(input logic [1:0] a);
      case (a)
         2'd0:    return {8'd0, m_mask};
         2'd1:    return {8'd0, m_mode};
         2'd2:    return {8'd0, m_view()};
         default: return {m_svc, 11'd0, m_idx};
      endcase
   endfunction

   task automatic model_update();
      logic [7:0] elig, lsb, clr, rise, old_mode;
      int w;
      if (!I_reset_n) begin
         m_mask = 0; m_mode = 0; m_pend = 0; h1 = 0; h2 = 0; h3 = 0;
         m_svc = 0; m_vld = 0; m_act = 0; m_num = 0; m_idx = 0;
         return;
      end
      rise     = h2 & ~h3;
      elig     = m_view() & m_mask;
      lsb      = elig & (~elig + 8'd1);
      w        = 0;
      for (int i = 0; i < 8; i++) if (lsb[i]) w = i;
      clr      = 0;
      old_mode = m_mode;
      if (!m_svc) begin
         m_act = (elig != 0) && !I_irq_ack;
         m_vld = 0;
         if (I_irq_ack && elig != 0) begin
            m_num = 16'(w); m_vld = 1; m_svc = 1; m_idx = 4'(w);
            clr = lsb & old_mode;
         end else if (I_irq_ack) begin
            m_num = 16'h00FF; m_vld = 1;
         end
      end else begin
         m_act = 0;
         if (I_eoi) begin m_svc = 0; m_vld = 0; end
      end
      if (I_reg_we) begin
         case (I_reg_addr)
            2'd0: m_mask = I_reg_wdata[7:0];
            2'd1: begin clr = clr | (old_mode ^ I_reg_wdata[7:0]); m_mode = I_reg_wdata[7:0]; end
            2'd2: clr = clr | (I_reg_wdata[7:0] & old_mode);
            default: ;
         endcase
      end
      m_pend = (m_pend & ~clr) | (rise & old_mode);
      h3 = h2; h2 = h1; h1 = I_irq;
   endtask

   task automatic tick();
      @(posedge I_clk);
      model_update();
      #1;
      chk("m_active", O_irq_active, m_act);
      chk("m_valid",  O_irq_number_valid, m_vld);
      chk("m_number", O_irq_number, m_num);
      chk("m_rdata",  O_reg_rdata, m_rdata(I_reg_addr));
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic wr(input logic [1:0] a, input logic [15:0] d);
      I_reg_we = 1; I_reg_addr = a; I_reg_wdata = d;
      tick();
      I_reg_we = 0;
   endtask

   task automatic rd(input logic [1:0] a, input logic [15:0] exp, input string tag);
      I_reg_addr = a;
      #1;
      chk(tag, O_reg_rdata, exp);
   endtask

   task automatic pulse_irq(input logic [7:0] v);
      I_irq = v; tick(); I_irq = 0;
   endtask

   task automatic ack();
      I_irq_ack = 1; tick(); I_irq_ack = 0;
   endtask

   task automatic eoi();
      I_eoi = 1; tick(); I_eoi = 0;
   endtask

   initial begin
      I_reset_n = 1; I_irq = 8'hFF; I_irq_ack = 0; I_eoi = 0;
      I_reg_we = 0; I_reg_addr = 0; I_reg_wdata = 0;
      #2 I_reset_n = 0;

      // reset with all lines high
      ticks(3);
      chk("rst_active", O_irq_active, 0);
      chk("rst_number", O_irq_number, 0);
      chk("rst_valid", O_irq_number_valid, 0);
      for (int a = 0; a < 4; a++) rd(2'(a), 16'h0000, "rst_reg");
      I_reset_n = 1;
      ticks(6);
      chk("mask0_active", O_irq_active, 0);
      I_irq = 0;
      ticks(4);

      // priority: lines 5 and 2 together
      wr(0, 16'h00FF);
      wr(1, 16'h00FF);
      pulse_irq(8'h24);
      ticks(2);
      chk("prio_act3", O_irq_active, 0);
      tick();
      chk("prio_act4", O_irq_active, 1);
      ack();
      chk("prio_num2", O_irq_number, 16'd2);
      chk("prio_vld2", O_irq_number_valid, 1);
      chk("prio_act_off", O_irq_active, 0);
      rd(2, 16'h0020, "prio_pend");
      rd(3, 16'h8002, "prio_status");
      ticks(2);
      chk("prio_hold", O_irq_number, 16'd2);
      eoi();
      chk("prio_eoi_vld", O_irq_number_valid, 0);
      chk("prio_eoi_num", O_irq_number, 16'd2);
      tick();
      chk("prio_react", O_irq_active, 1);
      ack();
      chk("prio_num5", O_irq_number, 16'd5);
      rd(3, 16'h8005, "prio_status5");
      eoi();
      tick();

      // level mode on line 0
      wr(1, 16'h0000);
      wr(0, 16'h0001);
      I_irq = 8'h01;
      ticks(4);
      chk("lvl_act", O_irq_active, 1);
      ack();
      chk("lvl_num", O_irq_number, 16'd0);
      chk("lvl_vld", O_irq_number_valid, 1);
      rd(2, 16'h0001, "lvl_pend_kept");
      eoi();
      tick();
      chk("lvl_react", O_irq_active, 1);
      I_irq = 0;
      ticks(4);
      chk("lvl_drop_act", O_irq_active, 0);
      rd(2, 16'h0000, "lvl_drop_pend");

      // spurious: W1C lands just before the ack, active still high
      wr(1, 16'h00FF);
      wr(0, 16'h00FF);
      pulse_irq(8'h08);
      ticks(3);
      chk("spur_act", O_irq_active, 1);
      wr(2, 16'h0008);
      chk("spur_act_race", O_irq_active, 1);
      ack();
      chk("spur_num", O_irq_number, 16'h00FF);
      chk("spur_vld", O_irq_number_valid, 1);
      rd(3, 16'h0000, "spur_status");
      tick();
      chk("spur_vld_off", O_irq_number_valid, 0);
      // W1C in the same cycle as ack: arbitration sees pre-write PENDING
      pulse_irq(8'h08);
      ticks(3);
      I_reg_we = 1; I_reg_addr = 2; I_reg_wdata = 16'h0008; I_irq_ack = 1;
      tick();
      I_reg_we = 0; I_irq_ack = 0;
      chk("w1c_ack_num", O_irq_number, 16'd3);
      rd(2, 16'h0000, "w1c_ack_pend");
      eoi();
      tick();

      // new edge on the serviced line
      pulse_irq(8'h02);
      ticks(3);
      ack();
      chk("svc_num1", O_irq_number, 16'd1);
      pulse_irq(8'h02);
      ticks(3);
      rd(2, 16'h0002, "svc_pend1");
      chk("svc_act_blk", O_irq_active, 0);
      chk("svc_num_hold", O_irq_number, 16'd1);
      eoi();
      tick();
      chk("svc_react", O_irq_active, 1);
      ack();
      eoi();
      tick();

      // asynchronous reset during service
      pulse_irq(8'h10);
      ticks(3);
      ack();
      chk("ar_num4", O_irq_number, 16'd4);
      #2 I_reset_n = 0;
      #1;
      chk("ar_active", O_irq_active, 0);
      chk("ar_number", O_irq_number, 0);
      chk("ar_valid", O_irq_number_valid, 0);
      rd(3, 16'h0000, "ar_status");
      ticks(2);
      I_reset_n = 1;
      ticks(2);
      wr(0, 16'h00FF);
      wr(1, 16'h00FF);
      pulse_irq(8'h40);
      ticks(3);
      chk("ar_new_act", O_irq_active, 1);
      ack();
      chk("ar_num6", O_irq_number, 16'd6);
      eoi();
      tick();

      // randomized traffic against the model
      for (int n = 0; n < 800; n++) begin
         if ($urandom_range(0, 2) == 0) I_irq = I_irq ^ (8'($urandom) & 8'($urandom));
         I_irq_ack   = ($urandom_range(0, 5) == 0);
         I_eoi       = ($urandom_range(0, 4) == 0);
         I_reg_we    = ($urandom_range(0, 5) == 0);
         I_reg_addr  = 2'($urandom);
         I_reg_wdata = 16'($urandom);
         tick();
      end
      I_irq_ack = 0; I_eoi = 0; I_reg_we = 0;
      tick();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
      $finish;
   end

endmodule
